pipelined_cla_adder: RTL and testbench

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

---
 rtl/pipelined_cla_adder_if.sv | 27 ++
 rtl/pipelined_cla_adder.sv | 116 +++++++++++
 tb/tb_pipelined_cla_adder.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder.
// master drives operands and result-ready; slave (the adder) drives results and input-ready.
interface pipelined_cla_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] i_add1;
  logic [WIDTH-1:0] i_add2;
  logic             i_carry;
  logic             i_sub;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] o_result;
  logic             o_carry;
  logic             o_overflow;
  logic             o_valid;
  logic             i_ready;

  modport master (
    output i_add1, i_add2, i_carry, i_sub, i_valid, i_ready,
    input  o_ready, o_result, o_carry, o_overflow, o_valid
  );

  modport slave (
    input  i_add1, i_add2, i_carry, i_sub, i_valid, i_ready,
    output o_ready, o_result, o_carry, o_overflow, o_valid
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined add/subtract: one 4-bit carry-lookahead group per stage.
// Unprocessed operand bits ride along in skew registers, finished sum bits in deskew
// registers, so each transaction leaves fully aligned after WIDTH/4 cycles.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH = 16
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  pipelined_cla_adder_if.slave bus
);
  localparam int STAGES = int'(WIDTH / 4);

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Whole pipe advances unless a finished result is blocked; subtract is A + ~B + 1.
  always_comb begin
    en      = bus.i_ready | ~bus.o_valid;
    b_eff   = bus.i_sub ? ~bus.i_add2 : bus.i_add2;
    cin_eff = bus.i_sub | bus.i_carry;
  end

  assign bus.o_ready = en;

  // Four-bit lookahead group; every carry is a flat function of g/p and ci. Returns {cout, sum}.
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    logic       co;
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {co, p ^ c};
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still to be processed from this stage upward.
    logic [WIDTH-1:4*k] a_in;
    logic [WIDTH-1:4*k] b_in;
    logic               cin;
    logic               v_in;
    logic [4:0]         grp;
    logic [4*k+3:0]     res_d;
    logic [4*k+3:0]     res_q;
    logic               valid_q;
    logic               carry_q;

    if (k == 0) begin : g_head
      assign a_in  = bus.i_add1;
      assign b_in  = b_eff;
      assign cin   = cin_eff;
      assign v_in  = bus.i_valid;
      assign res_d = grp[3:0];
    end else begin : g_body
      assign a_in  = g_stage[k-1].g_skew.a_q;
      assign b_in  = g_stage[k-1].g_skew.b_q;
      assign cin   = g_stage[k-1].carry_q;
      assign v_in  = g_stage[k-1].valid_q;
      assign res_d = {grp[3:0], g_stage[k-1].res_q};
    end

    assign grp = cla4(a_in[4*k+3:4*k], b_in[4*k+3:4*k], cin);

    // Capture this group's sum and carry-out, appending to the finished low bits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        res_q   <= '0;
      end else if (en) begin
        valid_q <= v_in;
        carry_q <= grp[4];
        res_q   <= res_d;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [WIDTH-1:4*k+4] a_q;
      logic [WIDTH-1:4*k+4] b_q;

      // Forward the not-yet-added operand bits alongside the transaction.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_in[WIDTH-1:4*k+4];
          b_q <= b_in[WIDTH-1:4*k+4];
        end
      end
    end else begin : g_tail
      logic ovf_q;

      // Carry into the MSB is recovered as a ^ b ^ sum at bit 3 of the top group.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= grp[4] ^ a_in[WIDTH-1] ^ b_in[WIDTH-1] ^ grp[3];
        end
      end

      assign bus.o_valid    = valid_q;
      assign bus.o_result   = res_q;
      assign bus.o_carry    = carry_q;
      assign bus.o_overflow = ovf_q;
    end
  end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed vectors on a 16-bit instance, a latency probe on a
// 4-bit instance, then random traffic on 4/16/32-bit instances against an arithmetic model.
module tb_pipelined_cla_adder;
  timeunit 1ns;
  timeprecision 1ps;

  typedef struct packed {
    logic        ovf;
    logic        cout;
    logic [63:0] res;
  } exp_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] res;
    logic        cout;
    logic        ovf;
  } vec_t;

  // a, b, cin, sub -> result, carry, overflow (hand computed)
  vec_t vecs [13] = '{
    '{16'h0003, 16'h000C, 1'b0, 1'b0, 16'h000F, 1'b0, 1'b0},
    '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
    '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
    '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0},
    '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0},
    '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0},
    '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1},
    '{16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0},
    '{16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0},
    '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1},
    '{16'hABCD, 16'h1234, 1'b1, 1'b0, 16'hBE02, 1'b0, 1'b0},
    '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0},
    '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1}
  };

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  exp_t exp4_q[$];
  exp_t exp16_q[$];
  exp_t exp32_q[$];
  logic [65:0] snap;
  int   lat;
  bit   acc4, acc16, acc32;

  pipelined_cla_adder_if #(.WIDTH(4))  bus4 ();
  pipelined_cla_adder_if #(.WIDTH(16)) bus16 ();
  pipelined_cla_adder_if #(.WIDTH(32)) bus32 ();

  pipelined_cla_adder #(.WIDTH(4))  u_dut4  (.i_clk(clk), .i_rst_n(rst_n), .bus(bus4.slave));
  pipelined_cla_adder #(.WIDTH(16)) u_dut16 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus16.slave));
  pipelined_cla_adder #(.WIDTH(32)) u_dut32 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus32.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub);
    logic [63:0] mask;
    logic [63:0] bb;
    logic [63:0] lo;
    logic [64:0] full;
    logic        ci;
    exp_t        m;
    mask   = (64'd1 << w) - 64'd1;
    bb     = (sub ? ~b : b) & mask;
    ci     = sub ? 1'b1 : cin;
    full   = {1'b0, a & mask} + {1'b0, bb} + {64'd0, ci};
    lo     = (a & (mask >> 1)) + (bb & (mask >> 1)) + {63'd0, ci};
    m.res  = full[63:0] & mask;
    m.cout = full[w];
    m.ovf  = full[w] ^ lo[w-1];
    return m;
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus4.i_add1 = '0;  bus4.i_add2 = '0;  bus4.i_carry = 1'b0;  bus4.i_sub = 1'b0;
    bus4.i_valid = 1'b0;  bus4.i_ready = 1'b1;
    bus16.i_add1 = '0; bus16.i_add2 = '0; bus16.i_carry = 1'b0; bus16.i_sub = 1'b0;
    bus16.i_valid = 1'b0; bus16.i_ready = 1'b1;
    bus32.i_add1 = '0; bus32.i_add2 = '0; bus32.i_carry = 1'b0; bus32.i_sub = 1'b0;
    bus32.i_valid = 1'b0; bus32.i_ready = 1'b1;
  endtask

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic send16(input vec_t v, input bit track);
    bit   acc;
    exp_t e;
    bus16.i_add1  = v.a;
    bus16.i_add2  = v.b;
    bus16.i_carry = v.cin;
    bus16.i_sub   = v.sub;
    bus16.i_valid = 1'b1;
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = bus16.o_ready;
      @(posedge clk);
    end
    if (!acc) begin
      check_eq("w16_accept_timeout", 66'd0, 66'd1);
    end else if (track) begin
      e.res  = 64'(v.res);
      e.cout = v.cout;
      e.ovf  = v.ovf;
      exp16_q.push_back(e);
    end
    #1;
    bus16.i_valid = 1'b0;
  endtask

  task automatic wait_lat16(output int l);
    l = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus16.o_valid) begin
        l = i;
        break;
      end
    end
  endtask

  task automatic drain_all();
    int t = 0;
    while ((exp4_q.size() + exp16_q.size() + exp32_q.size()) != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    sync();
    check_eq("drain", 66'(exp4_q.size() + exp16_q.size() + exp32_q.size()), 66'd0);
  endtask

  // Scoreboards: every result transfer must match the oldest outstanding expectation.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && bus16.o_valid && bus16.i_ready) begin
      if (exp16_q.size() == 0) check_eq("w16_spurious", 66'd1, 66'd0);
      else begin
        e = exp16_q.pop_front();
        check_eq("w16_out", {bus16.o_overflow, bus16.o_carry, 64'(bus16.o_result)}, e);
      end
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && bus4.o_valid && bus4.i_ready) begin
      if (exp4_q.size() == 0) check_eq("w4_spurious", 66'd1, 66'd0);
      else begin
        e = exp4_q.pop_front();
        check_eq("w4_out", {bus4.o_overflow, bus4.o_carry, 64'(bus4.o_result)}, e);
      end
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && bus32.o_valid && bus32.i_ready) begin
      if (exp32_q.size() == 0) check_eq("w32_spurious", 66'd1, 66'd0);
      else begin
        e = exp32_q.pop_front();
        check_eq("w32_out", {bus32.o_overflow, bus32.o_carry, 64'(bus32.o_result)}, e);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e4;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    idle_all();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid16",  66'(bus16.o_valid), 66'd0);
    check_eq("rst_result16", 66'(bus16.o_result), 66'd0);
    check_eq("rst_carry16",  66'(bus16.o_carry), 66'd0);
    check_eq("rst_ovf16",    66'(bus16.o_overflow), 66'd0);
    check_eq("rst_ready16",  66'(bus16.o_ready), 66'd1);
    check_eq("rst_valid4",   66'(bus4.o_valid), 66'd0);
    check_eq("rst_ready32",  66'(bus32.o_ready), 66'd1);
    sync();
    rst_n = 1'b1;

    // Simple add: four-cycle latency, one-cycle valid pulse.
    sync();
    send16(vecs[0], 1'b1);
    wait_lat16(lat);
    check_eq("lat16", 66'(lat), 66'd4);
    @(negedge clk);
    check_eq("valid_pulse", 66'(bus16.o_valid), 66'd0);

    // Carry/overflow and subtract vectors back to back.
    sync();
    for (int i = 1; i < 5; i++) send16(vecs[i], 1'b1);
    drain_all();

    // Stream eight, stall three cycles at the first result.
    fork
      begin
        for (int i = 5; i < 13; i++) send16(vecs[i], 1'b1);
      end
      begin
        int t;
        t = 0;
        while (!bus16.o_valid && t < 40) begin
          @(negedge clk);
          t++;
        end
        check_eq("stall_start", 66'(bus16.o_valid), 66'd1);
        sync();
        bus16.i_ready = 1'b0;
        snap = {bus16.o_overflow, bus16.o_carry, 64'(bus16.o_result)};
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check_eq("stall_ready", 66'(bus16.o_ready), 66'd0);
          check_eq("stall_valid", 66'(bus16.o_valid), 66'd1);
          check_eq("stall_hold", {bus16.o_overflow, bus16.o_carry, 64'(bus16.o_result)}, snap);
          @(posedge clk);
        end
        #1;
        bus16.i_ready = 1'b1;
      end
    join
    drain_all();

    // Reset with three in flight: they vanish, the next input still takes four cycles.
    for (int i = 0; i < 3; i++) send16(vecs[i + 1], 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst_flush_valid", 66'(bus16.o_valid), 66'd0);
    check_eq("rst_flush_ready", 66'(bus16.o_ready), 66'd1);
    sync();
    rst_n = 1'b1;
    send16(vecs[6], 1'b1);
    wait_lat16(lat);
    check_eq("lat_after_rst", 66'(lat), 66'd4);
    drain_all();

    // Single-stage build: 9 + 8 = 0x11 -> result 1, carry 1, signed overflow.
    bus4.i_add1 = 4'h9;
    bus4.i_add2 = 4'h8;
    bus4.i_carry = 1'b0;
    bus4.i_sub = 1'b0;
    bus4.i_valid = 1'b1;
    e4.res = 64'h1;
    e4.cout = 1'b1;
    e4.ovf = 1'b1;
    exp4_q.push_back(e4);
    sync();
    bus4.i_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus4.o_valid) begin
        lat = i;
        break;
      end
    end
    check_eq("lat4", 66'(lat), 66'd1);
    drain_all();

    // Random operands, modes and handshakes on all three widths.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      bus4.i_add1   = 4'($urandom);
      bus4.i_add2   = 4'($urandom);
      bus4.i_carry  = 1'($urandom_range(0, 1));
      bus4.i_sub    = 1'($urandom_range(0, 1));
      bus4.i_valid  = ($urandom_range(0, 3) != 0);
      bus4.i_ready  = ($urandom_range(0, 3) != 0);
      bus16.i_add1  = 16'($urandom);
      bus16.i_add2  = 16'($urandom);
      bus16.i_carry = 1'($urandom_range(0, 1));
      bus16.i_sub   = 1'($urandom_range(0, 1));
      bus16.i_valid = ($urandom_range(0, 3) != 0);
      bus16.i_ready = ($urandom_range(0, 3) != 0);
      bus32.i_add1  = $urandom;
      bus32.i_add2  = $urandom;
      bus32.i_carry = 1'($urandom_range(0, 1));
      bus32.i_sub   = 1'($urandom_range(0, 1));
      bus32.i_valid = ($urandom_range(0, 3) != 0);
      bus32.i_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc4  = bus4.i_valid & bus4.o_ready;
      acc16 = bus16.i_valid & bus16.o_ready;
      acc32 = bus32.i_valid & bus32.o_ready;
      @(posedge clk);
      if (acc4)
        exp4_q.push_back(model(4, 64'(bus4.i_add1), 64'(bus4.i_add2), bus4.i_carry, bus4.i_sub));
      if (acc16)
        exp16_q.push_back(model(16, 64'(bus16.i_add1), 64'(bus16.i_add2), bus16.i_carry,
                                bus16.i_sub));
      if (acc32)
        exp32_q.push_back(model(32, 64'(bus32.i_add1), 64'(bus32.i_add2), bus32.i_carry,
                                bus32.i_sub));
      #1;
    end
    idle_all();
    drain_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
